// File: rtl/l2_writeback_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_writeback_buffer_pkg
// Purpose  : Shared types for the L2 write-back buffer. These are the LC-3b
//            word/line types plus the write-back buffer line-address and
//            FSM state types.
// Contents : lc3b_word, lc3b_line, lc3b_wb_laddr, lc3b_wb_state, line_base()
// Revision : 1.0 - initial release
// ============================================================================
package l2_writeback_buffer_pkg;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;
   typedef logic [11:0]  lc3b_wb_laddr;

   typedef enum logic [1:0] {
      WB_IDLE  = 2'd0,
      WB_DRAIN = 2'd1,
      WB_FETCH = 2'd2,
      WB_DONE  = 2'd3
   } lc3b_wb_state;

   // Byte address of the first byte of a 16-byte line.
   function automatic lc3b_word line_base(input lc3b_wb_laddr laddr);
      return {laddr, 4'b0000};
   endfunction

endpackage
`default_nettype wire

// File: rtl/l2_writeback_buffer_cam.sv
`default_nettype none
// ============================================================================
// Module   : l2_wb_cam
// Purpose  : Combinational DEPTH-way line-address compare across the
//            write-back buffer entries. Entries are kept unique by
//            coalescing, so at most one way can match.
// Ports    : valid_i   - per-entry valid bits
//            laddr_i   - per-entry line addresses
//            key_i     - line address being looked up
//            hit_o     - some valid entry matches key_i
//            hit_idx_o - index of the matching entry (0 when no hit)
// Revision : 1.0 - initial release
// ============================================================================
module l2_wb_cam
   import l2_writeback_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]                valid_i,
   input  lc3b_wb_laddr [DEPTH-1:0]        laddr_i,
   input  lc3b_wb_laddr                    key_i,
   output logic                            hit_o,
   output logic [IDX_W-1:0]                hit_idx_o
);

   logic [DEPTH-1:0] match;

   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
         assign match[g] = valid_i[g] && (laddr_i[g] == key_i);
      end
   endgenerate

   always_comb begin
      hit_o     = |match;
      hit_idx_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (match[i]) begin
            hit_idx_o = IDX_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/l2_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : l2_writeback_buffer
// Purpose  : Coalescing write-back buffer between the L2 cache and DRAM.
//            Accepts L2 evictions in one cycle, serves L2 read misses from
//            buffered lines or DRAM, and drains buffered lines to DRAM in
//            FIFO order whenever the L2 side is quiet.
// Ports    : clk, rst_n                         - clock, async active-low reset
//            l2_pmem_addr/wdata/read/write     - L2 request side (held to resp)
//            l2_pmem_rdata/resp                - L2 response side
//            pmem_addr/wdata/read/write        - DRAM request side (held to resp)
//            pmem_rdata/resp                   - DRAM response side
//            wb_empty                          - no buffered lines
// Revision : 1.0 - initial release
// ============================================================================
module l2_writeback_buffer
   import l2_writeback_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [15:0]  l2_pmem_addr,
   input  logic [127:0] l2_pmem_wdata,
   input  logic         l2_pmem_read,
   input  logic         l2_pmem_write,
   output logic [127:0] l2_pmem_rdata,
   output logic         l2_pmem_resp,
   output logic [15:0]  pmem_addr,
   output logic [127:0] pmem_wdata,
   output logic         pmem_read,
   output logic         pmem_write,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp,
   output logic         wb_empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   // ---------------------------------------------------------------- state
   lc3b_wb_state              state_q, state_d;
   logic [IDX_W-1:0]          head_q, head_d;
   logic [IDX_W-1:0]          tail_q, tail_d;
   logic [CNT_W-1:0]          count_q, count_d;
   lc3b_line                  rdata_q, rdata_d;

   logic [DEPTH-1:0]          valid_q;
   lc3b_wb_laddr [DEPTH-1:0]  laddr_q;
   logic [DEPTH-1:0][127:0]   data_q;

   // ------------------------------------------------------------- controls
   logic                      push_en;
   logic                      ovw_en;
   logic                      pop_en;
   logic                      hit;
   logic [IDX_W-1:0]          hit_idx;
   logic                      full;
   lc3b_wb_laddr              req_laddr;

   // Offset bits within a line carry no meaning for a line buffer.
   logic                      unused_addr_lo;
   assign unused_addr_lo = ^l2_pmem_addr[3:0];

   assign req_laddr = l2_pmem_addr[15:4];
   assign full      = (count_q == CNT_W'(DEPTH));
   assign wb_empty  = (count_q == '0);

   assign l2_pmem_resp  = (state_q == WB_DONE);
   assign l2_pmem_rdata = rdata_q;

   l2_wb_cam #(
      .DEPTH     (DEPTH)
   ) u_cam (
      .valid_i   (valid_q),
      .laddr_i   (laddr_q),
      .key_i     (req_laddr),
      .hit_o     (hit),
      .hit_idx_o (hit_idx)
   );

   // ------------------------------------------- next state and DRAM outputs
   // DRAM outputs are decoded from the state register only (plus the held
   // L2 address in FETCH), so an asynchronous reset clears them at once.
   always_comb begin
      state_d    = state_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      rdata_d    = rdata_q;
      push_en    = 1'b0;
      ovw_en     = 1'b0;
      pop_en     = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      pmem_addr  = '0;
      pmem_wdata = '0;

      case (state_q)
         WB_IDLE: begin
            // Priority order matters: a write that hits coalesces even when
            // the buffer is full, and any L2 request beats a background drain.
            if (l2_pmem_write && hit) begin
               ovw_en  = 1'b1;
               state_d = WB_DONE;
            end else if (l2_pmem_write && !full) begin
               push_en = 1'b1;
               tail_d  = tail_q + IDX_W'(1);
               count_d = count_q + CNT_W'(1);
               state_d = WB_DONE;
            end else if (l2_pmem_write) begin
               // Make room; the write is still held and retried in IDLE.
               state_d = WB_DRAIN;
            end else if (l2_pmem_read && hit) begin
               rdata_d = data_q[hit_idx];
               state_d = WB_DONE;
            end else if (l2_pmem_read) begin
               // Safe to bypass buffered writes: the line is not buffered.
               state_d = WB_FETCH;
            end else if (count_q != '0) begin
               state_d = WB_DRAIN;
            end
         end

         WB_DRAIN: begin
            pmem_write = 1'b1;
            pmem_addr  = line_base(laddr_q[head_q]);
            pmem_wdata = data_q[head_q];
            if (pmem_resp) begin
               pop_en  = 1'b1;
               head_d  = head_q + IDX_W'(1);
               count_d = count_q - CNT_W'(1);
               state_d = WB_IDLE;
            end
         end

         WB_FETCH: begin
            pmem_read = 1'b1;
            pmem_addr = line_base(req_laddr);
            if (pmem_resp) begin
               rdata_d = pmem_rdata;
               state_d = WB_DONE;
            end
         end

         WB_DONE: begin
            state_d = WB_IDLE;
         end

         default: begin
            state_d = WB_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------ state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WB_IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         rdata_q <= rdata_d;
      end
   end

   // ------------------------------------------------------- entry storage
   // push, overwrite and pop come from mutually exclusive FSM branches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         laddr_q <= '0;
         data_q  <= '0;
      end else begin
         if (push_en) begin
            valid_q[tail_q] <= 1'b1;
            laddr_q[tail_q] <= req_laddr;
            data_q[tail_q]  <= l2_pmem_wdata;
         end
         if (ovw_en) begin
            data_q[hit_idx] <= l2_pmem_wdata;
         end
         if (pop_en) begin
            valid_q[head_q] <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_l2_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_writeback_buffer
// Purpose  : Self-checking bench for l2_writeback_buffer. Acts as the L2
//            requester and as a DRAM model. Expected read data comes from an
//            architectural memory image (last written value per line), and
//            DRAM write order comes from a FIFO of buffered lines.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_writeback_buffer;

   localparam int DEPTH = 4;

   logic         clk;
   logic         rst_n;
   logic [15:0]  l2_pmem_addr;
   logic [127:0] l2_pmem_wdata;
   logic         l2_pmem_read;
   logic         l2_pmem_write;
   logic [127:0] l2_pmem_rdata;
   logic         l2_pmem_resp;
   logic [15:0]  pmem_addr;
   logic [127:0] pmem_wdata;
   logic         pmem_read;
   logic         pmem_write;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;
   logic         wb_empty;

   l2_writeback_buffer #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .l2_pmem_addr  (l2_pmem_addr),
      .l2_pmem_wdata (l2_pmem_wdata),
      .l2_pmem_read  (l2_pmem_read),
      .l2_pmem_write (l2_pmem_write),
      .l2_pmem_rdata (l2_pmem_rdata),
      .l2_pmem_resp  (l2_pmem_resp),
      .pmem_addr     (pmem_addr),
      .pmem_wdata    (pmem_wdata),
      .pmem_read     (pmem_read),
      .pmem_write    (pmem_write),
      .pmem_rdata    (pmem_rdata),
      .pmem_resp     (pmem_resp),
      .wb_empty      (wb_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------ model
   typedef struct {
      logic [11:0]  la;
      logic [127:0] d;
   } ent_t;

   ent_t         mq[$];            // buffered lines, oldest first
   logic [127:0] dram [4096];      // DRAM contents
   logic [127:0] arch [4096];      // latest value of every line
   int           n_tests = 0;
   int           n_fail  = 0;
   int           dram_wr_cnt = 0;
   int           dram_rd_cnt = 0;
   bit           stall_wr = 1'b0;  // hold DRAM writes indefinitely
   int           fixed_lat = -1;   // <0: random DRAM latency
   bit           busy = 1'b0;
   int           lat_cnt = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int find_line(input logic [11:0] la);
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i].la == la) return i;
      end
      return -1;
   endfunction

   // ------------------------------------------------------- DRAM model
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy      = 1'b0;
            pmem_resp = 1'b0;
         end else if (pmem_resp) begin
            pmem_resp = 1'b0;
         end else if (pmem_read || pmem_write) begin
            if (!busy) begin
               busy    = 1'b1;
               lat_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
            end else if (pmem_write && stall_wr) begin
               // held
            end else if (lat_cnt > 0) begin
               lat_cnt--;
            end else begin
               check("dram_addr_align", 128'(pmem_addr[3:0]), 128'(0));
               if (pmem_write) begin
                  if (mq.size() == 0) begin
                     check("dram_wr_unexpected", 128'(pmem_addr), 128'hFFFF_FFFF);
                  end else begin
                     check("dram_wr_order_addr", 128'(pmem_addr[15:4]), 128'(mq[0].la));
                     check("dram_wr_data", pmem_wdata, mq[0].d);
                     void'(mq.pop_front());
                  end
                  dram[pmem_addr[15:4]] = pmem_wdata;
                  dram_wr_cnt++;
               end else begin
                  check("dram_rd_of_buffered_line", 128'(find_line(pmem_addr[15:4]) >= 0), 128'(0));
                  pmem_rdata = dram[pmem_addr[15:4]];
                  dram_rd_cnt++;
               end
               busy      = 1'b0;
               pmem_resp = 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------- L2 tasks
   task automatic l2_write(input logic [15:0] a, input logic [127:0] d, output int waits);
      int idx;
      @(negedge clk);
      l2_pmem_addr  = a;
      l2_pmem_wdata = d;
      l2_pmem_write = 1'b1;
      waits = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (!l2_pmem_resp && waits < 300);
      l2_pmem_write = 1'b0;
      check("wr_resp", 128'(l2_pmem_resp), 128'(1));
      if (l2_pmem_resp) begin
         idx = find_line(a[15:4]);
         if (idx >= 0) begin
            mq[idx].d = d;
         end else begin
            check("wr_room_in_buffer", 128'(mq.size() < DEPTH), 128'(1));
            mq.push_back('{la: a[15:4], d: d});
         end
         arch[a[15:4]] = d;
      end
   endtask

   task automatic l2_read(input logic [15:0] a, output int waits);
      @(negedge clk);
      l2_pmem_addr = a;
      l2_pmem_read = 1'b1;
      waits = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (!l2_pmem_resp && waits < 300);
      l2_pmem_read = 1'b0;
      check("rd_resp", 128'(l2_pmem_resp), 128'(1));
      check("rd_data", l2_pmem_rdata, arch[a[15:4]]);
   endtask

   task automatic wait_drain();
      int w = 0;
      while (!(wb_empty === 1'b1 && pmem_write === 1'b0) && w < 500) begin
         @(negedge clk);
         w++;
      end
      check("drain_empty", 128'(wb_empty), 128'(1));
      check("drain_model_empty", 128'(mq.size()), 128'(0));
   endtask

   task automatic wait_pmem_write();
      int w = 0;
      while (pmem_write !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
   endtask

   // ------------------------------------------------------- stimulus
   initial begin
      int           waits;
      int           wr0, rd0;
      logic [127:0] da, db, dc, dd;
      logic [11:0]  la;

      for (int i = 0; i < 4096; i++) begin
         dram[i] = {4{32'(i) * 32'h9E37_79B1 + 32'h1357}};
         arch[i] = dram[i];
      end
      rst_n         = 1'b0;
      l2_pmem_addr  = '0;
      l2_pmem_wdata = '0;
      l2_pmem_read  = 1'b0;
      l2_pmem_write = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_l2_resp",   128'(l2_pmem_resp), 128'(0));
      check("rst_wb_empty",  128'(wb_empty), 128'(1));
      check("rst_pmem_rd",   128'(pmem_read), 128'(0));
      check("rst_pmem_wr",   128'(pmem_write), 128'(0));
      check("rst_pmem_addr", 128'(pmem_addr), 128'(0));
      check("rst_rdata",     l2_pmem_rdata, 128'(0));
      rst_n = 1'b1;

      // Single write, then background drain
      da = {$urandom, $urandom, $urandom, $urandom};
      stall_wr = 1'b1;
      l2_write(16'h1230, da, waits);
      check("wr_latency", 128'(waits), 128'(1));
      wait_pmem_write();
      check("drain_pmem_write", 128'(pmem_write), 128'(1));
      check("drain_pmem_addr", 128'(pmem_addr), 128'h1230);
      check("drain_pmem_wdata", pmem_wdata, da);
      wr0 = dram_wr_cnt;
      stall_wr = 1'b0;
      wait_drain();
      check("drain_one_write", 128'(dram_wr_cnt - wr0), 128'(1));
      check("drain_dram_data", dram[12'h123], da);

      // Asynchronous reset in the middle of a drain
      stall_wr = 1'b1;
      l2_write(16'h2220, {$urandom, $urandom, $urandom, $urandom}, waits);
      wait_pmem_write();
      check("pre_rst_pmem_write", 128'(pmem_write), 128'(1));
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_pmem_write", 128'(pmem_write), 128'(0));
      check("async_rst_wb_empty", 128'(wb_empty), 128'(1));
      check("async_rst_l2_resp", 128'(l2_pmem_resp), 128'(0));
      mq.delete();
      arch[12'h222] = dram[12'h222];
      @(negedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      stall_wr = 1'b0;

      // Coalescing of two writes to the same line
      stall_wr = 1'b1;
      wr0 = dram_wr_cnt;
      da = {$urandom, $urandom, $urandom, $urandom};
      db = {$urandom, $urandom, $urandom, $urandom};
      l2_write(16'h1230, da, waits);
      l2_write(16'h1238, db, waits);
      check("coalesce_latency", 128'(waits), 128'(1));
      check("coalesce_not_empty", 128'(wb_empty), 128'(0));
      stall_wr = 1'b0;
      wait_drain();
      check("coalesce_one_write", 128'(dram_wr_cnt - wr0), 128'(1));
      check("coalesce_dram_data", dram[12'h123], db);

      // Read hit served from the buffer
      stall_wr = 1'b1;
      rd0 = dram_rd_cnt;
      dc = {$urandom, $urandom, $urandom, $urandom};
      l2_write(16'h4000, dc, waits);
      l2_read(16'h4004, waits);
      check("rdhit_latency", 128'(waits), 128'(1));
      check("rdhit_value", l2_pmem_rdata, dc);
      check("rdhit_no_dram_read", 128'(dram_rd_cnt - rd0), 128'(0));
      stall_wr = 1'b0;
      wait_drain();

      // Full buffer: oldest line drains before the new write is taken
      stall_wr = 1'b1;
      wr0 = dram_wr_cnt;
      for (int i = 1; i <= 4; i++) begin
         l2_write(16'(i * 16), {$urandom, $urandom, $urandom, $urandom}, waits);
         check("fill_latency", 128'(waits), 128'(1));
      end
      check("full_not_empty", 128'(wb_empty), 128'(0));
      stall_wr = 1'b0;
      l2_write(16'h0050, {$urandom, $urandom, $urandom, $urandom}, waits);
      check("full_one_drain_first", 128'(dram_wr_cnt - wr0), 128'(1));
      check("full_after_accept_not_empty", 128'(wb_empty), 128'(0));
      wait_drain();
      check("full_total_writes", 128'(dram_wr_cnt - wr0), 128'(5));
      check("full_last_line", dram[12'h005], arch[12'h005]);

      // Read miss with 5-cycle DRAM latency while a line is buffered
      stall_wr = 1'b1;
      dd = {$urandom, $urandom, $urandom, $urandom};
      l2_write(16'h1000, dd, waits);
      fixed_lat = 5;
      rd0 = dram_rd_cnt;
      l2_read(16'h7770, waits);
      check("rdmiss_latency", 128'(waits), 128'(5 + 3));
      check("rdmiss_value", l2_pmem_rdata, dram[12'h777]);
      check("rdmiss_one_dram_read", 128'(dram_rd_cnt - rd0), 128'(1));
      check("rdmiss_buffer_kept", 128'(wb_empty), 128'(0));
      fixed_lat = -1;
      stall_wr  = 1'b0;
      wait_drain();
      check("rdmiss_buffered_line_drained", dram[12'h100], dd);

      // Randomized traffic over a small set of lines
      for (int n = 0; n < 200; n++) begin
         la = 12'h300 + 12'($urandom_range(0, 7));
         if ($urandom_range(0, 2) != 0) begin
            l2_write({la, 4'($urandom)}, {$urandom, $urandom, $urandom, $urandom}, waits);
         end else begin
            l2_read({la, 4'($urandom)}, waits);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain();
      for (int i = 0; i < 8; i++) begin
         check("final_dram_image", dram[12'h300 + 12'(i)], arch[12'h300 + 12'(i)]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
